regfile_wb_scoreboard: RTL

- Owns the single write port of the general-purpose register file and arbitrates between two write-back sources: ALU and LSU.
- Holds a per-register busy scoreboard that blocks issue on RAW and WAW hazards.
- The register file has no write-to-read bypass, so this block guarantees that an issued instruction only reads values already committed to the array.
- Sits between decode/issue and the register file, in front of its write port.

---
 rtl/regfile_wb_scoreboard_pkg.sv | 12 +
 rtl/wb_rr_arbiter.sv | 36 +++
 rtl/regfile_wb_scoreboard.sv | 96 +++++++++
 3 files changed

// File: rtl/regfile_wb_scoreboard_pkg.sv
// Shared widths and grant encoding for the register-file write-back block.
package regfile_wb_scoreboard_pkg;
   localparam int RF_ADDR_W = 5;
   localparam int RF_NREG   = 32;
   localparam int RF_DATA_W = 64;
   localparam logic [RF_ADDR_W-1:0] ZERO_REG = '0;

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_LSU = 1'b1
   } grant_e;
endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin grant between ALU and LSU write-back requests.
module wb_rr_arbiter
   import regfile_wb_scoreboard_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic alu_req,
   input  logic lsu_req,
   output logic alu_gnt,
   output logic lsu_gnt
);

   grant_e last_grant;

   // Grants are suppressed while reset is asserted so nothing completes then.
   always_comb begin
      alu_gnt = 1'b0;
      lsu_gnt = 1'b0;
      if (rst_n) begin
         if (alu_req && (!lsu_req || last_grant == GRANT_LSU))
            alu_gnt = 1'b1;
         else if (lsu_req)
            lsu_gnt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         last_grant <= GRANT_LSU;
      else if (alu_gnt)
         last_grant <= GRANT_ALU;
      else if (lsu_gnt)
         last_grant <= GRANT_LSU;
   end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Register-file write port owner: ALU/LSU write-back arbitration plus a busy
// scoreboard that holds issue until sources and destination are committed.
module regfile_wb_scoreboard
   import regfile_wb_scoreboard_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NREG   = RF_NREG,
   parameter int DATA_W = RF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic [ADDR_W-1:0] issue_rs1,
   input  logic              issue_rs1_en,
   input  logic [ADDR_W-1:0] issue_rs2,
   input  logic              issue_rs2_en,
   output logic              issue_ready,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              lsu_valid,
   input  logic [ADDR_W-1:0] lsu_rd,
   input  logic [DATA_W-1:0] lsu_data,
   output logic              lsu_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [ADDR_W:0]   pend_cnt,
   output logic              wb_err
);

   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_nxt;
   logic              set_v;
   logic              inc;
   logic              dec;
   logic              wb_hs;
   logic [ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;

   wb_rr_arbiter u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .alu_req (alu_valid),
      .lsu_req (lsu_valid),
      .alu_gnt (alu_ready),
      .lsu_gnt (lsu_ready)
   );

   assign issue_ready = !(issue_rs1_en && busy[issue_rs1]) &&
                        !(issue_rs2_en && busy[issue_rs2]) &&
                        !(issue_rd != '0 && busy[issue_rd]);

   assign set_v   = issue_valid && issue_ready && issue_rd != '0;
   assign wb_hs   = alu_ready || lsu_ready;
   assign wb_rd   = alu_ready ? alu_rd : lsu_rd;
   assign wb_data = alu_ready ? alu_data : lsu_data;

   // Busy clears on the edge that commits the registered write; a same-cycle
   // set to the same register takes priority.
   always_comb begin
      busy_nxt = busy;
      if (rf_we)
         busy_nxt[rf_waddr] = 1'b0;
      if (set_v)
         busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   assign inc = set_v && !busy[issue_rd];
   assign dec = rf_we && busy[rf_waddr] && !(set_v && issue_rd == rf_waddr);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy     <= '0;
         pend_cnt <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         wb_err   <= 1'b0;
      end else begin
         busy     <= busy_nxt;
         pend_cnt <= pend_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
         rf_we    <= wb_hs && wb_rd != '0;
         if (wb_hs) begin
            rf_waddr <= wb_rd;
            rf_wdata <= wb_data;
         end
         if (wb_hs && wb_rd != '0 && !busy[wb_rd])
            wb_err <= 1'b1;
      end
   end

endmodule
